bypass_scoreboard: RTL

Parametrised forwarding and hazard unit for the RV32I pipeline. It keeps its own in-flight record of destination registers (rd, write-enable, load flag) for DEPTH stages behind decode. From that record it drives the operand bypass selects for NUM_SRC decode-stage sources and a load-use stall. It also counts stall cycles for performance monitoring.

---
 rtl/rv_pipe_pkg.sv | 13 +
 rtl/bypass_src_match.sv | 27 ++
 rtl/bypass_scoreboard.sv | 66 ++++++
 3 files changed

// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared in-flight entry type, constants and helpers for the RV32I pipeline hazard logic
package rv_pipe_pkg;
  typedef struct packed {
    logic       valid;
    logic       wr;
    logic       ld;
    logic [4:0] rd;
  } inflight_entry_t;
  localparam logic [4:0] REG_ZERO = 5'd0;
  function automatic int sel_width(input int depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/bypass_src_match.sv
// bypass_src_match: priority-encodes the youngest live producer of one source operand
module bypass_src_match
  import rv_pipe_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = sel_width(DEPTH)
) (
  input  logic [DEPTH*$bits(inflight_entry_t)-1:0] entries,
  input  logic [4:0]                               src_addr,
  input  logic                                     src_used,
  output logic [SEL_W-1:0]                         fwd_sel,
  output logic                                     hazard
);
  inflight_entry_t [DEPTH-1:0] ent;
  assign ent = entries;
  // Walk oldest to youngest so the lowest matching index is the last write
  always_comb begin
    fwd_sel = '0;
    hazard  = 1'b0;
    for (int j = DEPTH - 1; j >= 0; j--)
      if (src_used && ent[j].valid && ent[j].wr && ent[j].rd != REG_ZERO && ent[j].rd == src_addr) begin
        fwd_sel = SEL_W'(j + 1);
        hazard  = ent[j].ld && (j < LOAD_READY);
      end
  end
endmodule

// File: rtl/bypass_scoreboard.sv
// bypass_scoreboard: in-flight rd record driving operand bypass selects, load-use stall and a stall counter
module bypass_scoreboard
  import rv_pipe_pkg::*;
#(
  parameter int  NUM_SRC    = 2,
  parameter int  DEPTH      = 3,
  parameter int  LOAD_READY = 1,
  parameter int  CNT_W      = 32,
  localparam int SEL_W      = sel_width(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     advance,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic                     issue_reg_write,
  input  logic                     issue_is_load,
  input  logic [4:0]               issue_rd,
  input  logic [5*NUM_SRC-1:0]     src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic                     clr_count,
  output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_count
);
  inflight_entry_t [DEPTH-1:0] entries_q, entries_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [NUM_SRC-1:0]          hazard;

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    bypass_src_match #(
      .DEPTH     (DEPTH),
      .LOAD_READY(LOAD_READY),
      .SEL_W     (SEL_W)
    ) u_match (
      .entries (entries_q),
      .src_addr(src_addr[5*k +: 5]),
      .src_used(src_used[k]),
      .fwd_sel (fwd_sel[SEL_W*k +: SEL_W]),
      .hazard  (hazard[k])
    );
  end

  assign stall       = issue_valid & ~flush & |hazard;
  assign stall_count = count_q;

  // A stalled or flushed decode enters the record as a bubble
  always_comb begin
    entries_d = entries_q;
    if (advance) begin
      for (int j = DEPTH - 1; j > 0; j--) entries_d[j] = entries_q[j-1];
      entries_d[0] = (stall || flush) ? inflight_entry_t'('0)
                                      : inflight_entry_t'({issue_valid, issue_reg_write, issue_is_load, issue_rd});
    end
    count_d = clr_count ? '0 : (stall && advance && !(&count_q)) ? count_q + CNT_W'(1) : count_q;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      entries_q <= '0;
      count_q   <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
endmodule
